// File: rtl/filtro_pkg.sv
// Shared definitions for the filtro1 biquad controller: coefficient map,
// Q8.14 unity constant and controller state encoding.
package filtro_pkg;

  localparam int NCOEF = 5;

  localparam logic [2:0] ADDR_A1 = 3'd0;
  localparam logic [2:0] ADDR_A2 = 3'd1;
  localparam logic [2:0] ADDR_B0 = 3'd2;
  localparam logic [2:0] ADDR_B1 = 3'd3;
  localparam logic [2:0] ADDR_B2 = 3'd4;

  // 1.0 in Q8.14
  localparam int ONE = 16384;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  function automatic logic addr_valid(input logic [2:0] addr);
    return int'(addr) < NCOEF;
  endfunction

endpackage

// File: rtl/filtro_coef_bank.sv
// Shadow/active coefficient storage for one biquad section. Host writes land
// in the shadow bank; a commit copies it to the active bank only while idle.
module coef_bank
  import filtro_pkg::*;
#(
  parameter int ancho_p = 23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               idle,
  input  logic               cfg_wr,
  input  logic [2:0]         cfg_addr,
  input  logic [ancho_p-1:0] cfg_data,
  input  logic               cfg_commit,
  output logic               cfg_ack,
  output logic               cfg_err,
  output logic               commit_pending,
  output logic [ancho_p-1:0] a1,
  output logic [ancho_p-1:0] a2,
  output logic [ancho_p-1:0] b0,
  output logic [ancho_p-1:0] b1,
  output logic [ancho_p-1:0] b2
);

  typedef logic [NCOEF-1:0][ancho_p-1:0] bank_t;

  // Passthrough biquad: b0 = 1.0, everything else zero.
  function automatic bank_t reset_bank();
    bank_t b;
    b          = '0;
    b[ADDR_B0] = ancho_p'(ONE);
    return b;
  endfunction

  bank_t shadow_q, shadow_d, active_q;
  logic  wr_ok, copy;

  assign wr_ok = cfg_wr & addr_valid(cfg_addr);
  assign copy  = idle & commit_pending;

  // A write landing on the copy edge is folded into the copied bank.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_ok) shadow_d[cfg_addr] = cfg_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: both banks are small flop arrays and get a reset value, so the
      // section is a clean passthrough from the very first sample.
      shadow_q       <= reset_bank();
      active_q       <= reset_bank();
      commit_pending <= 1'b0;
      cfg_ack        <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (copy) active_q <= shadow_d;
      commit_pending <= copy ? 1'b0 : (commit_pending | cfg_commit);
      cfg_ack        <= wr_ok;
      cfg_err        <= cfg_wr & ~addr_valid(cfg_addr);
    end
  end

  assign a1 = active_q[ADDR_A1];
  assign a2 = active_q[ADDR_A2];
  assign b0 = active_q[ADDR_B0];
  assign b1 = active_q[ADDR_B1];
  assign b2 = active_q[ADDR_B2];

endmodule

// File: rtl/filtro_ctrl.sv
// Sample sequencer for biquad filtro1: present sample, wait for the pipeline
// to settle, capture the result and pulse the delay-line enable.
module filtro_ctrl
  import filtro_pkg::*;
#(
  parameter int ancho_p = 23,
  parameter int lat     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               smp_valid,
  input  logic [ancho_p-1:0] smp_in,
  output logic [ancho_p-1:0] smp_out,
  output logic               smp_out_valid,
  output logic               busy,
  output logic               overrun,
  input  logic               clr_overrun,
  input  logic               cfg_wr,
  input  logic [2:0]         cfg_addr,
  input  logic [ancho_p-1:0] cfg_data,
  output logic               cfg_ack,
  output logic               cfg_err,
  input  logic               cfg_commit,
  output logic               commit_pending,
  output logic [ancho_p-1:0] func_ent,
  output logic               en,
  input  logic [ancho_p-1:0] func_sal,
  output logic [ancho_p-1:0] a1,
  output logic [ancho_p-1:0] a2,
  output logic [ancho_p-1:0] b0,
  output logic [ancho_p-1:0] b1,
  output logic [ancho_p-1:0] b2
);

  localparam logic [3:0] CNT_INIT = 4'(lat - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept, capture;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (smp_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        en      = 1'b1;
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      func_ent      <= '0;
      smp_out       <= '0;
      smp_out_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with <= only, so every flop samples
      // the pre-edge values regardless of statement order.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      smp_out_valid <= capture;
      if (accept)  func_ent <= smp_in;
      if (capture) smp_out  <= func_sal;
      // A drop on the same edge as a clear request keeps the flag set.
      if (smp_valid && busy) overrun <= 1'b1;
      else if (clr_overrun)  overrun <= 1'b0;
    end
  end

  coef_bank #(.ancho_p(ancho_p)) u_coef_bank (
    .clk            (clk),
    .reset          (reset),
    .idle           (state_q == IDLE),
    .cfg_wr         (cfg_wr),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .cfg_ack        (cfg_ack),
    .cfg_err        (cfg_err),
    .commit_pending (commit_pending),
    .a1             (a1),
    .a2             (a2),
    .b0             (b0),
    .b1             (b1),
    .b2             (b2)
  );

endmodule

// File: tb/tb_filtro_ctrl.sv
// Scoreboard bench for filtro_ctrl: cycle-level reference model, stand-in
// biquad on func_ent/func_sal, directed cases followed by random traffic.
module tb_filtro_ctrl;

  localparam int W   = 23;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         smp_valid = 1'b0;
  logic [W-1:0] smp_in = '0;
  logic [W-1:0] smp_out;
  logic         smp_out_valid, busy, overrun;
  logic         clr_overrun = 1'b0;
  logic         cfg_wr = 1'b0;
  logic [2:0]   cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_ack, cfg_err;
  logic         cfg_commit = 1'b0;
  logic         commit_pending;
  logic [W-1:0] func_ent, func_sal;
  logic         en;
  logic [W-1:0] a1, a2, b0, b1, b2;

  always #5 clk = ~clk;

  filtro_ctrl #(.ancho_p(W), .lat(LAT)) dut (
    .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_in(smp_in),
    .smp_out(smp_out), .smp_out_valid(smp_out_valid), .busy(busy),
    .overrun(overrun), .clr_overrun(clr_overrun), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .cfg_err(cfg_err), .cfg_commit(cfg_commit), .commit_pending(commit_pending),
    .func_ent(func_ent), .en(en), .func_sal(func_sal),
    .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2)
  );

  // Stand-in biquad: combinational function of sample and coefficients.
  function automatic logic signed [W-1:0] biq(input logic signed [W-1:0] x, c_a1, c_a2, c_b0, c_b1, c_b2);
    longint acc;
    acc = (longint'(x) * longint'(c_b0)) >>> 14;
    acc = acc + (longint'(c_a1) >>> 1) - longint'(c_a2) + longint'(c_b1) + 2 * longint'(c_b2);
    return W'(acc);
  endfunction

  assign func_sal = biq(func_ent, a1, a2, b0, b1, b2);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; logic [W-1:0] val; } exp_t;
  exp_t         sbq[$];
  logic [W-1:0] m_shadow[5];
  logic [W-1:0] m_active[5];
  logic [W-1:0] m_fent;
  bit           m_pending, m_overrun, m_ack, m_err;
  int           t_free;   // first cycle the controller is idle again

  task automatic model_init();
    for (int i = 0; i < 5; i++) begin
      m_shadow[i] = (i == 2) ? W'(16384) : '0;
      m_active[i] = m_shadow[i];
    end
    m_fent = '0; m_pending = 0; m_overrun = 0; m_ack = 0; m_err = 0;
    t_free = 0;
    sbq.delete();
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_init();
    end else begin
      bit idle;
      idle  = (cyc >= t_free);
      m_ack = cfg_wr && (cfg_addr < 3'd5);
      m_err = cfg_wr && (cfg_addr >= 3'd5);
      if (m_ack) m_shadow[cfg_addr] = cfg_data;
      if (idle && m_pending) begin
        m_active  = m_shadow;
        m_pending = 0;
      end else if (cfg_commit) m_pending = 1;
      if (smp_valid && !idle) m_overrun = 1;
      else if (clr_overrun)   m_overrun = 0;
      if (smp_valid && idle) begin
        sbq.push_back('{due: cyc + LAT + 2,
                        val: biq(smp_in, m_active[0], m_active[1], m_active[2], m_active[3], m_active[4])});
        t_free = cyc + LAT + 2;
        m_fent = smp_in;
      end
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      bit exp_valid;
      check("busy", busy, cyc < t_free);
      check("en", en, (t_free > 0) && (cyc == t_free - 1));
      check("overrun", overrun, m_overrun);
      check("commit_pending", commit_pending, m_pending);
      check("cfg_ack", cfg_ack, m_ack);
      check("cfg_err", cfg_err, m_err);
      check("func_ent", func_ent, m_fent);
      check("a1", a1, m_active[0]);
      check("a2", a2, m_active[1]);
      check("b0", b0, m_active[2]);
      check("b1", b1, m_active[3]);
      check("b2", b2, m_active[4]);
      exp_valid = (sbq.size() > 0) && (sbq[0].due == cyc);
      check("smp_out_valid", smp_out_valid, exp_valid);
      if (exp_valid) begin
        if (smp_out_valid) check("smp_out", smp_out, sbq[0].val);
        void'(sbq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [W-1:0] x, input bit wr, input logic [2:0] ad,
                       input logic [W-1:0] d, input bit cm, input bit cl);
    @(negedge clk); #1;
    smp_valid = v; smp_in = x; cfg_wr = wr; cfg_addr = ad;
    cfg_data = d; cfg_commit = cm; clr_overrun = cl;
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive(0, '0, 0, 3'd0, '0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_en"}, en, 0);
    check({tag, "_valid"}, smp_out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_smp_out"}, smp_out, 0);
    check({tag, "_func_ent"}, func_ent, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_pending"}, commit_pending, 0);
    check({tag, "_ack_err"}, {cfg_ack, cfg_err}, 0);
    check({tag, "_b0"}, b0, 16384);
    check({tag, "_a1"}, a1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    @(negedge clk); #1 reset = 1'b1;

    // Passthrough: en only in cycle 5, result in cycle 6.
    drive(1, W'(1000), 0, 3'd0, '0, 0, 0);
    idle_n(3);
    @(negedge clk); check("pass_en_c4", en, 0);
    @(negedge clk); check("pass_en_c5", en, 1);
    @(negedge clk); check("pass_en_c6", en, 0);
    check("pass_valid", smp_out_valid, 1);
    check("pass_out", smp_out, 1000);

    // b0 = 0.5 committed while idle.
    drive(0, '0, 1, 3'd2, W'(8192), 0, 0);
    drive(0, '0, 0, 3'd0, '0, 1, 0);
    idle_n(2);
    @(negedge clk); check("half_b0", b0, 8192);
    drive(1, W'(2000), 0, 3'd0, '0, 0, 0);
    idle_n(5);
    @(negedge clk); check("half_out", smp_out, 1000);

    // a1 written and committed mid-sample: held until back in IDLE.
    drive(1, W'(500), 0, 3'd0, '0, 0, 0);
    drive(0, '0, 1, 3'd0, W'(777), 1, 0);
    idle_n(2);
    @(negedge clk); check("busy_pending", commit_pending, 1); check("busy_a1", a1, 0);
    @(negedge clk); check("capture_a1", a1, 0);
    @(negedge clk); check("after_cap_pending", commit_pending, 1);
    check("after_cap_a1", a1, 0);
    @(negedge clk); check("commit_done", commit_pending, 0); check("a1_new", a1, 777);

    // Overrun: second strobe at cycle 3, sticky, then cleared.
    drive(1, W'(100), 0, 3'd0, '0, 0, 0);
    idle_n(2);
    drive(1, W'(200), 0, 3'd0, '0, 0, 0);
    @(negedge clk); check("ovr_set", overrun, 1);
    idle_n(8);
    @(negedge clk); check("ovr_held", overrun, 1);
    drive(0, '0, 0, 3'd0, '0, 0, 1);
    @(negedge clk); check("ovr_clr", overrun, 0);
    drive(1, W'(300), 0, 3'd0, '0, 0, 0);
    drive(1, W'(400), 0, 3'd0, '0, 0, 1);
    @(negedge clk); check("ovr_set_wins", overrun, 1);
    idle_n(8);
    drive(0, '0, 0, 3'd0, '0, 0, 1);

    // Back-to-back at exactly LAT+2 cycles is legal.
    drive(1, W'(10), 0, 3'd0, '0, 0, 0);
    idle_n(LAT + 1);
    drive(1, W'(20), 0, 3'd0, '0, 0, 0);
    @(negedge clk); check("b2b_no_ovr", overrun, 0); check("b2b_func_ent", func_ent, 20);
    idle_n(LAT + 3);

    // Invalid address: error pulse only, shadow untouched.
    drive(0, '0, 1, 3'd6, W'(12345), 0, 0);
    @(negedge clk); check("bad_err", cfg_err, 1); check("bad_ack", cfg_ack, 0);
    drive(0, '0, 0, 3'd0, '0, 1, 0);
    idle_n(2);
    @(negedge clk); check("bad_b0", b0, 8192); check("bad_a2", a2, 0);

    // Random traffic, scored by the monitor.
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 4) == 0, W'($urandom), ($urandom % 8) == 0, 3'($urandom % 8),
            W'($urandom), ($urandom % 12) == 0, ($urandom % 10) == 0);
    idle_n(LAT + 4);

    // Reset in cycle 3 of a sample: discarded, everything back to reset values.
    drive(1, W'(1234), 0, 3'd0, '0, 0, 0);
    idle_n(2);
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_values("midrst");
    end
    @(negedge clk); #1 reset = 1'b1;
    idle_n(10);
    drive(1, W'(4321), 0, 3'd0, '0, 0, 0);
    idle_n(5);
    @(negedge clk); check("post_rst_valid", smp_out_valid, 1); check("post_rst_out", smp_out, 4321);

    idle_n(LAT + 4);
    check("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filtro_ctrl.md
# filtro_ctrl

Sequencing and coefficient-configuration controller for one biquad section (filtro1) of the equalizer. Accepts one audio sample per strobe, presents it to the biquad, waits for the free-running pipeline to settle, captures the result, then pulses the biquad's state-advance enable. Also owns the five coefficients, using a shadow/active bank so that a host update takes effect only between samples.

## Interface
- ancho_p, 23: sample/coefficient width, signed fixed point Q8.14 (1 sign, 8 integer, 14 fraction bits).
- lat, 4: settle cycles between presenting a sample and capturing func_sal; legal range 1..15.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; the controller is in reset while reset=0.
- smp_valid  in  1  one-cycle sample strobe.
- smp_in  in  ancho_p  signed input sample.
- smp_out  out  ancho_p  signed filtered sample.
- smp_out_valid  out  1  one-cycle pulse; smp_out is valid in that cycle.
- busy  out  1  sample in flight.
- overrun  out  1  sticky; a sample arrived while busy.
- clr_overrun  in  1  clears overrun.
- cfg_wr  in  1  one-cycle coefficient write request.
- cfg_addr  in  3  0=a1, 1=a2, 2=b0, 3=b1, 4=b2; values 5..7 are invalid.
- cfg_data  in  ancho_p  coefficient value, Q8.14.
- cfg_ack  out  1  pulses the cycle after a valid write.
- cfg_err  out  1  pulses the cycle after a write to an invalid address.
- cfg_commit  in  1  requests shadow→active copy.
- commit_pending  out  1  commit requested but not yet applied.
- func_ent  out  ancho_p  to biquad input, registered.
- en  out  1  to biquad delay-line enable.
- func_sal  in  ancho_p  from biquad output.
- a1, a2, b0, b1, b2  out  ancho_p each  active coefficients.

## Operation
- The FSM has three states: IDLE, SETTLE and CAPTURE.
  - IDLE with smp_valid: func_ent<=smp_in, cnt<=lat-1, go to SETTLE.
  - SETTLE: decrement cnt; at cnt=0 go to CAPTURE.
  - CAPTURE: en=1 for exactly this cycle; smp_out<=func_sal; smp_out_valid<=1; go to IDLE.
- busy=1 in SETTLE and CAPTURE. func_ent holds its value until the next accepted sample.
- smp_valid while busy: the sample is dropped and overrun<=1. If set and clr_overrun happen in the same cycle, set wins.
- Coefficient writes:
  - A write goes into the shadow bank at any time, including while busy; active coefficients are unaffected.
  - A write to address 5..7 changes nothing and produces cfg_err.
- Commit:
  - cfg_commit sets commit_pending.
  - The shadow→active copy happens on the first clock edge where state=IDLE and commit_pending=1; that same edge clears commit_pending.
  - If a sample is accepted on that edge, the sample uses the new coefficients.
  - cfg_wr and cfg_commit in the same cycle: the write is included in the copy.
  - cfg_commit while already pending has no further effect.
- Reset values:
  - Shadow and active banks: b0=16384 (1.0), all others 0, giving passthrough.
  - Outputs: func_ent=0, smp_out=0, and all strobes/flags 0.
  - State: IDLE.
- Reset asserted mid-sample: the in-flight sample is discarded with no smp_out_valid and no en. Pending commit and shadow contents return to reset values.
- No saturation in the controller; all values pass through bit-exact.

## Timing
- smp_valid in cycle 0 → SETTLE in cycles 1..lat → CAPTURE (en=1) in cycle lat+1 → smp_out_valid in cycle lat+2.
- Latency is lat+2 cycles; the minimum accepted sample spacing is lat+2 cycles (back-to-back at exactly lat+2 is legal).
- en is a Moore output and is never high outside CAPTURE.
- cfg_ack/cfg_err are registered, one cycle after cfg_wr.
- An active-coefficient change is visible on a1..b2 in the cycle after the copy edge; coefficients never change during SETTLE or CAPTURE.

## Structure
- Package filtro_pkg holds:
  - coefficient address constants (ADDR_A1..ADDR_B2, NCOEF=5);
  - Q8.14 constant ONE=16384;
  - FSM state encoding.
- Sub-module coef_bank holds the shadow array, active array, write decode, ack/err generation and commit_pending logic.
- The top level holds the FSM, settle counter, sample registers and overrun logic.

## Test plan
- Passthrough after reset, lat=4: smp_in=1000 at cycle 0 → en high in cycle 5 only; smp_out=1000 with smp_out_valid in cycle 6 (biquad attached).
- Write b0=8192 and commit in IDLE, then smp_in=2000 → active b0=8192 next cycle; smp_out=1000.
- Write a1 while busy with commit in the same cycle → commit_pending=1 until the cycle after CAPTURE; a1 does not change during SETTLE/CAPTURE and updates on the return to IDLE.
- Second smp_valid at cycle 3 with lat=4 → dropped, overrun=1 and held; clr_overrun → 0. Same-cycle set+clear → stays 1.
- cfg_wr with cfg_addr=6 → cfg_err pulse one cycle later, no cfg_ack, shadow unchanged.
- reset=0 in cycle 3 of a sample → no en, no smp_out_valid; all outputs at reset values; b0=16384.
